rsa_word_packer: RTL
====================

Name: rsa_word_packer

Overview:
- Upstream feeder for rsa_wrapper's 1024-bit operand input (arm_to_fpga_data / _valid / _ready).
- Accepts 32-bit words from the ARM-side bus and assembles them into 1024-bit blocks.
- Presents each completed block on a valid/ready interface.
- Double-buffered: the next block can be filled while the previous one waits for the consumer.
- Supports short operands (e.g. 512-bit modulus, 16 words) via an in_last early terminator with zero padding.

Parameters:
- WORD_W, 32, input word width.
- BLOCK_W, 1024, output block width; must be an integer multiple of WORD_W.
- WORDS, BLOCK_W/WORD_W (32), derived; words per block.
- IDX_W, $clog2(WORDS) (5), derived; word index width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort; discards all buffered data.
- in_word  in  WORD_W  input word.
- in_word_valid  in  1  in_word is valid.
- in_word_ready  out  1  packer accepts in_word this cycle.
- in_last  in  1  qualifies in_word; marks the final word of the current block.
- out_data  out  BLOCK_W  assembled block, connects to arm_to_fpga_data.
- out_data_valid  out  1  out_data holds a complete block.
- out_data_ready  in  1  consumer takes out_data this cycle.
- word_count  out  IDX_W+1  words accepted into the current assembly block.
- blocks_sent  out  16  count of completed output handshakes; wraps 0xFFFF->0.

Behaviour:
- Reset (asynchronous, reset=1): asm_reg=0, out_reg=0, idx=0, state=FILL, out_data_valid=0, blocks_sent=0, word_count=0.
- Word accept: accept = in_word_valid & in_word_ready.
  - in_word_ready = (state==FILL) & ~flush. Purely combinational; no dependence on in_word_valid.
- Word order is little-endian: the k-th accepted word of a block lands in bits [k*WORD_W +: WORD_W]. Word 0 is the LSW.
- Each block starts from asm_reg=0. An early in_last therefore leaves all higher words zero.
- Completion event: accept & (idx==WORDS-1 | in_last).
  - The completing word is merged into the block image in the same edge.
  - The ready beat for the completion is idx==WORDS-1, or idx<WORDS-1 with in_last=1.
- Output buffer free: drain = ~out_data_valid | out_data_ready.
- state FILL:
  - accept without completion: write word, idx++.
  - completion with drain=1: at the same edge, out_reg <= merged image, out_data_valid=1, asm_reg=0, idx=0, stay FILL.
  - completion with drain=0: asm_reg <= merged image, state <= FULL, idx held at completion count.
- state FULL (in_word_ready=0):
  - on out_data_valid & out_data_ready: out_reg <= asm_reg, out_data_valid stays 1, asm_reg=0, idx=0, state <= FILL.
- Output handshake: out_data_valid & out_data_ready drops out_data_valid the next edge, unless a refill occurs at that same edge (FILL completion or FULL transfer).
  - blocks_sent increments on every output handshake.
- out_data and out_data_valid are stable while out_data_valid=1 and out_data_ready=0.
  - out_data comes directly from a register; no combinational path from inputs.
- Latency: completing word accepted at edge N gives out_data_valid=1 from edge N. One-cycle path word -> block.
- Throughput: one word per cycle sustained, provided the consumer drains at least one block per WORDS cycles.
- in_last with in_word_valid=0 is ignored.
- in_last on word index WORDS-1 is identical to a normal completion.
- word_count = idx. Reads 0 right after a completion in FILL; reads the completion count in FULL.
- flush (synchronous, highest priority below reset):
  - clears asm_reg, idx, out_data_valid and state.
  - does not clear out_reg data bits or blocks_sent.
  - a word presented with flush is dropped, since in_word_ready=0.
  - flush coincident with an output handshake does not count in blocks_sent.
- Reset mid-block or mid-handshake: all state lost immediately. The partial block is never emitted.

Decomposition:
- Shared package rsa_pkg: WORD_W, BLOCK_W, WORDS, IDX_W constants; packer state enum {FILL, FULL}.
- Single module, no sub-module. The assembly and output registers are two instances of the same simple register logic and stay inline.

Test Plan:
- Full block: 32 words 0x00000000..0x0000001F back-to-back, out_data_ready=1 -> one block with bits[31:0]=0x0, bits[1023:992]=0x1F; out_data_valid high exactly one cycle, from the edge of word 31; blocks_sent=1.
- Short operand: 16 words of the modulus a1223da6...6d379c4d (LSW first, in_last on word 15) -> out_data[511:0] equals the modulus, out_data[1023:512]=0.
- Backpressure:
  - Setup: out_data_ready=0; send block A (32×0xAAAAAAAA), then block B (32×0xBBBBBBBB).
  - Required: after B's last word, in_word_ready=0, state FULL, word_count=32; out_data stays all-A while held.
  - Release: raise ready one cycle -> out_data switches to all-B with valid continuously high; in_word_ready returns to 1; blocks_sent=1.
- Flush: 10 words accepted, then flush=1 with in_word_valid=1 -> word dropped, word_count=0. The next 32 words form a clean block with no residue.
- Reset mid-operation: assert reset after 20 words with out_data_valid=1 -> out_data_valid=0, in_word_ready=1, word_count=0, blocks_sent=0 immediately (asynchronous, before next clk edge).
- Counter wrap: preload via 65536 single-word in_last blocks -> blocks_sent returns to 0; the last block out_data[31:0] matches its word.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared constants and types for the RSA operand path.
// The word packer builds 1024-bit operand blocks from 32-bit bus words.
package rsa_pkg;

  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 1024;
  localparam int WORDS   = BLOCK_W / WORD_W;
  localparam int IDX_W   = $clog2(WORDS);

  // FILL: assembling a block. FULL: a finished block waits behind the output register.
  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } packer_state_e;

endpackage

// File: rtl/rsa_word_packer.sv
// Packs 32-bit ARM-side words, little-endian, into 1024-bit blocks for rsa_wrapper.
// Double-buffered: asm_reg assembles the next block while out_reg waits for the consumer.
module rsa_word_packer
  import rsa_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic [WORD_W-1:0]  in_word,
  input  logic               in_word_valid,
  output logic               in_word_ready,
  input  logic               in_last,
  output logic [BLOCK_W-1:0] out_data,
  output logic               out_data_valid,
  input  logic               out_data_ready,
  output logic [IDX_W:0]     word_count,
  output logic [15:0]        blocks_sent,
  output packer_state_e      dbg_state
);

  // Valid/ready: a transfer happens on any rising edge where valid and ready
  // are both high; ready never depends on valid, and a raised valid keeps its
  // payload stable until the transfer.

  localparam logic [IDX_W:0] LAST_IDX = (IDX_W+1)'(WORDS - 1);

  packer_state_e      state, state_n;
  logic [BLOCK_W-1:0] asm_reg, asm_n;
  logic [BLOCK_W-1:0] out_reg, out_n;
  logic               valid_q, valid_n;
  logic [IDX_W:0]     idx, idx_n;
  logic [15:0]        sent_q, sent_n;

  logic               accept;
  logic               complete;
  logic               drain;
  logic               handshake;
  logic [BLOCK_W-1:0] merged;

  assign in_word_ready  = (state == FILL) & ~flush;
  assign accept         = in_word_valid & in_word_ready;
  assign complete       = accept & ((idx == LAST_IDX) | in_last);
  assign drain          = ~valid_q | out_data_ready;
  assign handshake      = valid_q & out_data_ready;

  assign out_data       = out_reg;
  assign out_data_valid = valid_q;
  assign word_count     = idx;
  assign blocks_sent    = sent_q;
  assign dbg_state      = state;

  // Block image with the incoming word placed in its slot; idx only reaches
  // WORDS in FULL, where the merge result is not used.
  always_comb begin
    merged = asm_reg;
    merged[int'(idx[IDX_W-1:0])*WORD_W +: WORD_W] = in_word;
  end

  always_comb begin
    state_n = state;
    asm_n   = asm_reg;
    out_n   = out_reg;
    valid_n = valid_q;
    idx_n   = idx;
    sent_n  = sent_q;

    if (flush) begin
      asm_n   = '0;
      idx_n   = '0;
      valid_n = 1'b0;
      state_n = FILL;
    end else begin
      if (handshake) begin
        sent_n  = sent_q + 16'd1;
        valid_n = 1'b0;
      end

      case (state)
        FILL: begin
          if (complete && drain) begin
            out_n   = merged;
            valid_n = 1'b1;
            asm_n   = '0;
            idx_n   = '0;
          end else if (complete) begin
            // Output still occupied: park the block and hold the count.
            asm_n   = merged;
            idx_n   = idx + 1'b1;
            state_n = FULL;
          end else if (accept) begin
            asm_n   = merged;
            idx_n   = idx + 1'b1;
          end
        end
        FULL: begin
          if (handshake) begin
            out_n   = asm_reg;
            valid_n = 1'b1;
            asm_n   = '0;
            idx_n   = '0;
            state_n = FILL;
          end
        end
        default: state_n = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FILL;
      asm_reg <= '0;
      out_reg <= '0;
      valid_q <= 1'b0;
      idx     <= '0;
      sent_q  <= '0;
    end else begin
      state   <= state_n;
      asm_reg <= asm_n;
      out_reg <= out_n;
      valid_q <= valid_n;
      idx     <= idx_n;
      sent_q  <= sent_n;
    end
  end

endmodule
